// File: rtl/example_drv_pkg.sv
// example_drv_pkg
//   Shared definitions for the call driver: data and sum widths, and the
//   batch-control FSM state encoding.
//   Optional feature macro used by the top: EXAMPLE_CALL_DRIVER_SUM_EN.
package example_drv_pkg;

    localparam int DATA_W = 32;
    localparam int SUM_W  = 48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } drv_state_e;

endpackage

// File: rtl/example_drv_fifo.sv
// example_drv_fifo
//   First-word-fall-through result buffer. The head entry is always visible
//   on 'head' while 'empty' is low. A push on a full buffer or a pop on an
//   empty buffer is ignored. Push and pop may happen together.
// Ports:
//   clock, resetn         - clock, asynchronous active-low reset
//   push, din             - write request and data
//   pop                   - consume head entry
//   full, empty, count    - registered occupancy status
//   head                  - oldest entry
module example_drv_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only visible after it is written.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/example_call_driver.sv
// example_call_driver
//   Issues a batch of num_calls calls to a component, collects the returns
//   into a result buffer and streams them downstream in return order.
//   Issue is throttled so that every outstanding call is guaranteed a slot
//   in the result buffer.
// Ports:
//   clock, resetn                 - clock, asynchronous active-low reset
//   run, num_calls                - batch start pulse and batch size
//   comp_start, comp_busy         - call valid / call stall
//   comp_done, comp_stall,
//   comp_returndata               - return valid / backpressure / data
//   res_valid, res_ready, res_data- downstream result stream
//   active, complete, protocol_err- batch status, end pulse, sticky error
//   result_sum                    - wrapping sum of accepted returns
//                                   (only with EXAMPLE_CALL_DRIVER_SUM_EN)
module example_call_driver
    import example_drv_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              run,
    input  logic [CNT_W-1:0]  num_calls,
    output logic              comp_start,
    input  logic              comp_busy,
    input  logic              comp_done,
    output logic              comp_stall,
    input  logic [DATA_W-1:0] comp_returndata,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              active,
    output logic              complete,
    output logic              protocol_err
`ifdef EXAMPLE_CALL_DRIVER_SUM_EN
    ,
    output logic [SUM_W-1:0]  result_sum
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    drv_state_e        state;
    logic [CNT_W-1:0]  n_q;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  received;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W:0]    occ;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [DATA_W-1:0] fifo_head;

    logic              run_acc;
    logic              call_acc;
    logic              last_call;
    logic              ret_acc;
    logic              ret_ok;
    logic              ret_bad;
    logic              drain_done;

    assign outstanding = issued - received;
    // Calls in flight plus results already buffered must fit the buffer,
    // so a return can never find the buffer full because of our own issue.
    assign occ         = {1'b0, outstanding} + (CNT_W+1)'(fifo_count);

    // Occupancy cannot grow while a call is stalled (each push retires one
    // outstanding call), so comp_start holds until the call is accepted.
    assign comp_start  = (state == ST_ISSUE) && (issued < n_q) &&
                         (occ < (CNT_W+1)'(FIFO_DEPTH));
    assign comp_stall  = fifo_full;
    assign active      = (state == ST_ISSUE) || (state == ST_DRAIN);

    assign run_acc     = run && (state == ST_IDLE);
    assign call_acc    = comp_start && !comp_busy;
    assign last_call   = call_acc && ((issued + CNT_W'(1)) == n_q);
    assign ret_acc     = comp_done && !comp_stall;
    assign ret_ok      = ret_acc && (outstanding != '0);
    assign ret_bad     = ret_acc && (outstanding == '0);
    assign drain_done  = (state == ST_DRAIN) && (received == n_q) && fifo_empty;

    assign res_valid   = !fifo_empty;
    assign res_data    = fifo_empty ? '0 : fifo_head;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            n_q          <= '0;
            complete     <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            complete <= (run_acc && (num_calls == '0)) || drain_done;
            if (ret_bad) protocol_err <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (run_acc && (num_calls != '0)) begin
                        state <= ST_ISSUE;
                        n_q   <= num_calls;
                    end
                end
                ST_ISSUE: if (last_call)  state <= ST_DRAIN;
                ST_DRAIN: if (drain_done) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            issued   <= '0;
            received <= '0;
        end else if (run_acc) begin
            issued   <= '0;
            received <= '0;
        end else begin
            if (call_acc) issued   <= issued + CNT_W'(1);
            if (ret_ok)   received <= received + CNT_W'(1);
        end
    end

`ifdef EXAMPLE_CALL_DRIVER_SUM_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)      result_sum <= '0;
        else if (run_acc) result_sum <= '0;
        else if (ret_ok)  result_sum <= result_sum + SUM_W'(comp_returndata);
    end
`endif

    example_drv_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (ret_ok),
        .pop    (res_valid && res_ready),
        .din    (comp_returndata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count),
        .head   (fifo_head)
    );

endmodule

// File: tb/tb_example_call_driver.sv
// tb_example_call_driver
//   Randomized bench with a component model and a result scoreboard.
//   The driver process issues stimulus and predicts handshakes from a
//   queue-level model; a separate monitor pops expected results whenever
//   the DUT presents one.
module tb_example_call_driver;

    localparam int D = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        run = 1'b0;
    logic [15:0] num_calls = '0;
    logic        comp_busy = 1'b0;
    logic        comp_done = 1'b0;
    logic [31:0] comp_returndata = '0;
    logic        res_ready = 1'b0;
    logic        comp_start, comp_stall, res_valid, active, complete, protocol_err;
    logic [31:0] res_data;
`ifdef EXAMPLE_CALL_DRIVER_SUM_EN
    logic [47:0] result_sum;
`endif

    example_call_driver #(.FIFO_DEPTH(D), .CNT_W(16)) dut (
        .clock           (clock),
        .resetn          (resetn),
        .run             (run),
        .num_calls       (num_calls),
        .comp_start      (comp_start),
        .comp_busy       (comp_busy),
        .comp_done       (comp_done),
        .comp_stall      (comp_stall),
        .comp_returndata (comp_returndata),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_data        (res_data),
        .active          (active),
        .complete        (complete),
        .protocol_err    (protocol_err)
`ifdef EXAMPLE_CALL_DRIVER_SUM_EN
        ,
        .result_sum      (result_sum)
`endif
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    // Model: calls pending in the component, results expected downstream.
    logic [31:0] comp_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] dir_q[$];
    int  iss_m = 0, rcv_m = 0, n_m = 0;
    bit  m_active = 0, m_complete = 0, perr_m = 0;

    int  busy_pct = 0, done_pct = 100, ready_pct = 100, force_busy = 0;
    bit  spurious = 0, run_i = 0;
    int  num_i = 0;
    int  complete_cnt = 0;
    int  res_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] gen_data();
        if (dir_q.size() > 0) return dir_q.pop_front();
        return $urandom();
    endfunction

    task automatic clear_model();
        comp_q.delete();
        exp_q.delete();
        iss_m = 0; rcv_m = 0; n_m = 0;
        m_active = 0; m_complete = 0; perr_m = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_comp_start"}, comp_start, 0);
        chk({tag, "_comp_stall"}, comp_stall, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_complete"}, complete, 0);
        chk({tag, "_active"}, active, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_protocol_err"}, protocol_err, 0);
    endtask

    // One clock: drive at negedge, evaluate the upcoming posedge 1ns later.
    task automatic cycle();
        bit exp_start, nxt_active, nxt_complete;
        @(negedge clock);
        run       = run_i;
        num_calls = 16'(num_i);
        comp_busy = (force_busy > 0) ? 1'b1 : ($urandom_range(99) < busy_pct);
        if (force_busy > 0) force_busy--;
        if (spurious) begin
            comp_done = 1'b1; comp_returndata = $urandom();
        end else if (comp_q.size() > 0 && $urandom_range(99) < done_pct) begin
            comp_done = 1'b1; comp_returndata = comp_q[0];
        end else begin
            comp_done = 1'b0; comp_returndata = '0;
        end
        res_ready = ($urandom_range(99) < ready_pct);
        #1;
        if (!resetn) return;
        exp_start = m_active && (iss_m < n_m) && ((comp_q.size() + exp_q.size()) < D);
        chk("comp_start", comp_start, exp_start);
        chk("active", active, m_active);
        chk("complete", complete, m_complete);
        chk("comp_stall", comp_stall, exp_q.size() == D);
        chk("res_valid", res_valid, exp_q.size() != 0);
        chk("protocol_err", protocol_err, perr_m);
        if (complete) complete_cnt++;
        nxt_active = m_active; nxt_complete = 0;
        if (!m_active && run) begin
            if (num_i == 0) nxt_complete = 1;
            else begin nxt_active = 1; n_m = num_i; iss_m = 0; rcv_m = 0; end
        end else if (m_active && iss_m == n_m && rcv_m == n_m && exp_q.size() == 0) begin
            nxt_active = 0; nxt_complete = 1;
        end
        if (comp_start && !comp_busy) begin
            iss_m++;
            comp_q.push_back(gen_data());
        end
        if (comp_done && !comp_stall) begin
            if (comp_q.size() == 0) perr_m = 1;
            else begin exp_q.push_back(comp_q.pop_front()); rcv_m++; end
        end
        m_active = nxt_active; m_complete = nxt_complete;
    endtask

    task automatic start_batch(input int n, output int base);
        base = res_seen;
        complete_cnt = 0;
        run_i = 1; num_i = n;
        cycle();
        run_i = 0;
    endtask

    task automatic finish_batch(input int n, input int base);
        int k;
        for (k = 0; k < 3000; k++) begin
            if (complete_cnt > 0) break;
            cycle();
        end
        if (complete_cnt == 0) begin
            n_chk++; n_fail++;
            $display("FAIL batch_timeout: got no complete within 3000 cycles, n=%0d", n);
        end
        repeat (3) cycle();
        chk("batch_complete_cnt", complete_cnt, 1);
        chk("batch_results", res_seen - base, n);
    endtask

    task automatic run_batch(input int n);
        int base;
        start_batch(n, base);
        finish_batch(n, base);
    endtask

    task automatic apply_reset();
        run_i = 0; spurious = 0; force_busy = 0;
        @(negedge clock);
        run = 0; comp_done = 0; comp_busy = 0;
        resetn = 0;
        #1;
        clear_model();
        check_zero("reset");
        repeat (2) @(negedge clock);
        resetn = 1;
    endtask

    // Scoreboard monitor.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (resetn && res_valid && res_ready) begin
                res_seen++;
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL res_unexpected: got %0h expected no result", res_data);
                end else begin
                    chk("res_data", res_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int base, cnt, k;
        clear_model();
        repeat (2) @(negedge clock);
        #1;
        check_zero("reset_init");
        @(negedge clock);
        resetn = 1;

        // Three calls, fixed return data, full-speed downstream.
        busy_pct = 0; done_pct = 100; ready_pct = 100;
        dir_q.push_back(32'h11); dir_q.push_back(32'h22); dir_q.push_back(32'h33);
        run_batch(3);

        // Downstream blocked: issue stops at buffer depth, then resumes.
        ready_pct = 0;
        start_batch(8, base);
        repeat (20) cycle();
        chk("throttle_issued", iss_m, 4);
        chk("throttle_start", comp_start, 0);
        chk("throttle_stall", comp_stall, 1);
        ready_pct = 100;
        finish_batch(8, base);

        // Component stalls the first call for 5 cycles.
        start_batch(2, base);
        force_busy = 5;
        cnt = 0;
        repeat (5) begin
            cycle();
            if (comp_start) cnt++;
        end
        chk("busy_hold_start", cnt, 5);
        chk("busy_hold_issued", iss_m, 0);
        cycle();
        chk("busy_release_issued", iss_m, 1);
        finish_batch(2, base);

        // Return with nothing outstanding: dropped, sticky error.
        spurious = 1;
        cycle();
        spurious = 0;
        repeat (4) cycle();
        chk("perr_sticky", protocol_err, 1);
        chk("perr_no_result", res_valid, 0);
        apply_reset();

        // Asynchronous reset mid-batch, then a fresh single-call batch.
        done_pct = 0;
        start_batch(5, base);
        for (k = 0; k < 20 && iss_m < 2; k++) cycle();
        chk("midrst_issued", iss_m, 2);
        @(negedge clock);
        #3;
        resetn = 0;
        comp_done = 0;
        #1;
        check_zero("async_rst");
        clear_model();
        repeat (2) @(negedge clock);
        resetn = 1;
        done_pct = 100;
        run_batch(1);

        // Randomized batches.
        for (int b = 0; b < 12; b++) begin
            busy_pct  = $urandom_range(60);
            done_pct  = 20 + $urandom_range(80);
            ready_pct = 20 + $urandom_range(80);
            run_batch(1 + $urandom_range(11));
        end

        // Empty batch: complete on the next cycle only.
        busy_pct = 0; done_pct = 100; ready_pct = 100;
        run_batch(0);

`ifdef EXAMPLE_CALL_DRIVER_SUM_EN
        dir_q.push_back(32'hFFFF_FFFF); dir_q.push_back(32'hFFFF_FFFF);
        run_batch(2);
        chk("sum_wrap", result_sum, 48'h0001_FFFF_FFFE);
        start_batch(0, base);
        cycle();
        chk("sum_zero_complete", complete, 1);
        chk("sum_cleared", result_sum, 0);
        repeat (2) cycle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
